// File: rtl/rf_pkg.sv
// Shared constants and types for the default RISC-V register file configuration.
package rf_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_NR     = 2;

  typedef logic [4:0]  rf_addr_t;
  typedef logic [31:0] rf_data_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits with issue-over-writeback priority and a registered
// population count of the pending vector.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH    = RF_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic              write_enable_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  output logic [DEPTH-1:0]  pend_o,
  output logic [ADDR_W:0]   busy_count_o
);
  localparam int CW = ADDR_W + 1;

  logic [DEPTH-1:0] pend_nxt;
  logic [ADDR_W:0]  cnt_nxt;

  // Clear first, then set: a new producer issued alongside the old one's
  // writeback keeps the register pending.
  always_comb begin
    pend_nxt = pend_o;
    if (write_enable_i) pend_nxt[write_addr_i] = 1'b0;
    if (issue_valid_i)  pend_nxt[issue_addr_i] = 1'b1;
    if (ZERO_REG != 0)  pend_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + CW'(pend_nxt[i]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_o       <= '0;
      busy_count_o <= '0;
    end else begin
      pend_o       <= pend_nxt;
      busy_count_o <= cnt_nxt;
    end
  end
endmodule

// File: rtl/rf_riscv_sb.sv
// Register file with integrated scoreboard. Define RF_BYPASS_EN to forward
// same-cycle writeback data (and clear the busy bit) onto matching read ports.
module rf_riscv_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NR       = RF_NR,
  parameter int ZERO_REG = 1,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 write_enable_i,
  input  logic [ADDR_W-1:0]    write_addr_i,
  input  logic [DATA_W-1:0]    write_data_i,
  input  logic [NR*ADDR_W-1:0] read_addr_i,
  output logic [NR*DATA_W-1:0] read_data_o,
  output logic [NR-1:0]        read_busy_o,
  input  logic                 issue_valid_i,
  input  logic [ADDR_W-1:0]    issue_addr_i,
  output logic [ADDR_W:0]      busy_count_o
);
  // issue_valid_i and write_enable_i are single-cycle strobes with no ready:
  // the register file accepts both on every rising edge they are high.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              wr_ok;

  assign wr_ok = write_enable_i && !((ZERO_REG != 0) && (write_addr_i == '0));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[write_addr_i] <= write_data_i;
    end
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .issue_valid_i  (issue_valid_i),
    .issue_addr_i   (issue_addr_i),
    .write_enable_i (write_enable_i),
    .write_addr_i   (write_addr_i),
    .pend_o         (pend),
    .busy_count_o   (busy_count_o)
  );

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zero_hit;
    assign ra       = read_addr_i[k*ADDR_W +: ADDR_W];
    assign zero_hit = (ZERO_REG != 0) && (ra == '0);
`ifdef RF_BYPASS_EN
    logic byp;
    assign byp = write_enable_i && (write_addr_i == ra) && !zero_hit;
    assign read_data_o[k*DATA_W +: DATA_W] = zero_hit ? '0 : (byp ? write_data_i : mem[ra]);
    assign read_busy_o[k] = byp ? (issue_valid_i && (issue_addr_i == ra)) : pend[ra];
`else
    assign read_data_o[k*DATA_W +: DATA_W] = zero_hit ? '0 : mem[ra];
    assign read_busy_o[k] = pend[ra];
`endif
  end
endmodule

// File: tb/tb_rf_riscv_sb.sv
// Randomised and directed bench for rf_riscv_sb (NR=4) against a set/map model.
module tb_rf_riscv_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NRP = 4;
  localparam int EW = NRP*DW + NRP + AW + 1;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              write_enable_i = 1'b0;
  logic [AW-1:0]     write_addr_i = '0;
  logic [DW-1:0]     write_data_i = '0;
  logic [NRP*AW-1:0] read_addr_i = '0;
  logic [NRP*DW-1:0] read_data_o;
  logic [NRP-1:0]    read_busy_o;
  logic              issue_valid_i = 1'b0;
  logic [AW-1:0]     issue_addr_i = '0;
  logic [AW:0]       busy_count_o;

  rf_riscv_sb #(.DATA_W(DW), .DEPTH(32), .NR(NRP), .ZERO_REG(1)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .write_enable_i (write_enable_i),
    .write_addr_i   (write_addr_i),
    .write_data_i   (write_data_i),
    .read_addr_i    (read_addr_i),
    .read_data_o    (read_data_o),
    .read_busy_o    (read_busy_o),
    .issue_valid_i  (issue_valid_i),
    .issue_addr_i   (issue_addr_i),
    .busy_count_o   (busy_count_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // reference model: register contents as a sparse map, pending regs as a set
  logic [DW-1:0] regs_m[int];
  bit            pend_m[int];
  logic [EW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  function automatic logic [DW-1:0] reg_val(int a);
    if (a == 0) return '0;
    return regs_m.exists(a) ? regs_m[a] : '0;
  endfunction

  // driver: called at posedge+1, holds inputs through the next rising edge
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic iv, input logic [AW-1:0] ia,
                      input logic [NRP*AW-1:0] ra, input bit do_rst);
    logic [NRP*DW-1:0] ed;
    logic [NRP-1:0]    eb;
    logic [AW:0]       ec;
    rst_i = 1'b0;
    write_enable_i = we; write_addr_i = wa; write_data_i = wd;
    issue_valid_i = iv; issue_addr_i = ia; read_addr_i = ra;
    if (do_rst) begin
      #2 rst_i = 1'b1;
      regs_m.delete();
      pend_m.delete();
    end
    for (int k = 0; k < NRP; k++) begin
      int  a;
      bit  byp;
      a   = int'(ra[k*AW +: AW]);
      byp = BYP && we && (int'(wa) == a) && (a != 0);
      ed[k*DW +: DW] = (a == 0) ? '0 : (byp ? wd : reg_val(a));
      eb[k] = byp ? (iv && (int'(ia) == a)) : pend_m.exists(a);
    end
    ec = (AW+1)'(pend_m.num());
    exp_q.push_back({ed, eb, ec});
    @(posedge clk_i);
    if (!rst_i) begin
      if (we && wa != 0) regs_m[int'(wa)] = wd;
      if (we) pend_m.delete(int'(wa));
      if (iv && ia != 0) pend_m[int'(ia)] = 1'b1;
    end
    #1;
  endtask

  task automatic rd(input logic [NRP*AW-1:0] ra);
    step(1'b0, '0, '0, 1'b0, '0, ra, 1'b0);
  endtask

  function automatic logic [NRP*AW-1:0] all4(input logic [AW-1:0] a);
    return {a, a, a, a};
  endfunction

  // monitor / scoreboard: outputs are sampled mid-cycle on the falling edge
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (read_data_o !== e[EW-1 -: NRP*DW]) begin
          n_err++;
          $display("FAIL read_data addr=%h got=%h exp=%h", read_addr_i, read_data_o, e[EW-1 -: NRP*DW]);
        end
        n_vec++;
        if (read_busy_o !== e[AW+NRP -: NRP]) begin
          n_err++;
          $display("FAIL read_busy addr=%h got=%b exp=%b", read_addr_i, read_busy_o, e[AW+NRP -: NRP]);
        end
        n_vec++;
        if (busy_count_o !== e[AW:0]) begin
          n_err++;
          $display("FAIL busy_count got=%0d exp=%0d", busy_count_o, e[AW:0]);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    // reset state over all addresses
    for (int i = 0; i < 32; i += 4)
      rd({AW'(i+3), AW'(i+2), AW'(i+1), AW'(i)});
    // r0 is hard-wired
    step(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, '0, all4(5'd0), 1'b0);
    rd(all4(5'd0));
    // issue then writeback
    step(1'b0, '0, '0, 1'b1, 5'd5, all4(5'd5), 1'b0);
    rd(all4(5'd5));
    step(1'b1, 5'd5, 32'h12345678, 1'b0, '0, all4(5'd5), 1'b0);
    rd(all4(5'd5));
    // issue wins over same-cycle writeback
    step(1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, all4(5'd7), 1'b0);
    rd({5'd7, 5'd5, 5'd7, 5'd0});
    // all ports on one register
    step(1'b1, 5'd3, 32'h000000FF, 1'b0, '0, all4(5'd3), 1'b0);
    rd(all4(5'd3));
    step(1'b0, '0, '0, 1'b1, 5'd3, all4(5'd3), 1'b0);
    rd(all4(5'd3));
    // same-cycle writeback to a pending register while reading it
    step(1'b0, '0, '0, 1'b1, 5'd9, all4(5'd9), 1'b0);
    step(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, '0, {5'd9, 5'd9, 5'd3, 5'd9}, 1'b0);
    rd(all4(5'd9));
    // issue streak with asynchronous reset in the middle
    for (int i = 1; i < 32; i++)
      step(1'b0, '0, '0, 1'b1, AW'(i), {AW'(i), AW'(i-1), 5'd3, 5'd9}, (i == 16));
    rd({5'd31, 5'd17, 5'd16, 5'd15});
    // randomized traffic
    for (int n = 0; n < 400; n++)
      step(1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom_range(0, 2) == 0),
           AW'($urandom), (NRP*AW)'($urandom), ($urandom_range(0, 99) == 0));
    @(negedge clk_i);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rf_riscv_sb.md
Name: rf_riscv_sb

Overview:
- Parametrised register file for the RISC-V core. Configurable data width, register count and read-port count.
- Adds an integrated scoreboard: one pending bit per register, set at instruction issue and cleared at writeback.
- Lets the pipelined core's hazard unit stall on register operands that are still in flight.
- Sits between decode/issue (read and issue ports) and the writeback stage (write port).

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of architectural registers; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), register index width (derived; do not override).
- NR, 2, number of independent read ports; 1..4.
- ZERO_REG, 1, 1 = register 0 hard-wired to zero and never marked pending; 0 = register 0 is an ordinary register.

Ports:
- clk_i, in, 1, clock; all state updates on the rising edge.
- rst_i, in, 1, reset, asynchronous, active-high.
- write_enable_i, in, 1, writeback strobe.
- write_addr_i, in, ADDR_W, writeback destination.
- write_data_i, in, DATA_W, writeback data.
- read_addr_i, in, NR*ADDR_W, packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- read_data_o, out, NR*DATA_W, packed read data; port k uses bits [k*DATA_W +: DATA_W].
- read_busy_o, out, NR, pending bit of the register addressed by each read port.
- issue_valid_i, in, 1, an instruction with a destination register issues this cycle.
- issue_addr_i, in, ADDR_W, destination of the issuing instruction.
- busy_count_o, out, $clog2(DEPTH)+1, number of registers currently pending.

Behaviour:
- Reset (async, rst_i=1):
  - All registers are cleared to 0 and all pending bits to 0.
  - read_data_o then reflects zeros; read_busy_o=0; busy_count_o=0.
  - Reset asserted mid-operation discards any in-flight issue or write on that edge.
- Write: on a rising edge with write_enable_i=1, mem[write_addr_i] <= write_data_i. Ignored when ZERO_REG=1 and write_addr_i=0.
- Read: combinational, zero added latency. read_data_o[k] = mem[read_addr_i[k]]. With ZERO_REG=1, address 0 always returns 0.
- All read ports are independent; any ports may read the same address.
- Scoreboard, per register r, on each rising edge:
  - set = issue_valid_i && issue_addr_i==r.
  - clr = write_enable_i && write_addr_i==r.
  - set has priority: set&&clr leaves pend[r]=1, because a new producer was issued.
  - clr alone gives pend[r]=0. set alone gives pend[r]=1.
  - With ZERO_REG=1, pend[0] is held at 0.
- Writeback to a non-pending register is legal: data is written and the pending bit stays 0.
- Issue to an already-pending register (WAW) keeps pend=1. Only one pending bit exists; the core must not issue a second producer before the first writes back. No counter per register.
- read_busy_o[k] = pend[read_addr_i[k]], the registered value (see Optional Feature for same-cycle writeback).
- busy_count_o is a registered population count of the pend vector, updated in the same cycle as pend. It never exceeds DEPTH-ZERO_REG.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - A read port whose address equals write_addr_i while write_enable_i=1 returns write_data_i combinationally.
  - Its read_busy_o bit is forced to 0, unless issue_valid_i targets the same address in the same cycle.
  - Address 0 with ZERO_REG=1 is never bypassed.
- Undefined: the read returns the old stored value and the registered pend bit until the next edge. The hazard unit must stall one extra cycle.

Decomposition:
- Package rf_pkg holds:
  - default constants RF_DATA_W=32, RF_DEPTH=32, RF_NR=2;
  - typedef rf_addr_t (logic [4:0]) and rf_data_t (logic [31:0]) for the default core configuration.
- One natural sub-module: rf_scoreboard (DEPTH, ZERO_REG).
  - Owns the pend vector, the set/clear priority and busy_count.
  - Instantiated once. The storage array and read muxing stay in the top module.

Test Plan:
- Reset then read all ports at addresses 0..31 -> every read_data 0, read_busy 0, busy_count 0. Write 0xDEADBEEF to r0 (ZERO_REG=1) -> r0 still reads 0.
- Issue r5, next cycle read r5 -> read_busy=1, busy_count=1. Write 0x12345678 to r5 -> after the edge read_data=0x12345678, read_busy=0, busy_count=0.
- Same cycle: issue r7 and write r7=0xA5A5A5A5 -> after the edge pend[7]=1, data=0xA5A5A5A5, busy_count=1.
- NR=4, all ports read r3 while r3=0x0000_00FF -> all four read_data=0xFF. Issue r3 -> all four read_busy=1.
- RF_BYPASS_EN defined: r9 pending, write r9=0xCAFEF00D and read r9 in the same cycle -> read_data=0xCAFEF00D, read_busy=0. Undefined: old value returned and read_busy=1.
- Issue r1..r31 on consecutive cycles, assert rst_i asynchronously mid-sequence between edges -> outputs clear immediately, busy_count=0, following issues count from 1.
